// File: rtl/pixel_uart_serializer.sv
// rtl/pixel_uart_serializer.sv - pixel FIFO feeding a UART transmitter (8N1; 8E1 when SERIALIZER_PARITY_EN is defined)
module pixel_uart_serializer #(
  parameter int CLKS_PER_BIT = 1736,
  parameter int FIFO_DEPTH   = 16,
  parameter int FRAME_PIXELS = 3721
) (
  input  logic       clk_200mhz,
  input  logic       reset_n,
  input  logic [7:0] pixel_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_out,
  output logic       busy,
  output logic       frame_done
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int PIX_W  = $clog2(FRAME_PIXELS + 1);

  localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(FRAME_PIXELS - 1);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t             state, state_d;
  logic [BAUD_W-1:0]  baud, baud_d;
  logic [2:0]         bit_idx, bit_idx_d;
  logic [7:0]         shift_reg, shift_d;
  logic [PIX_W-1:0]   pix_cnt, pix_d;
  logic               tx_d, busy_d, done_d;
  logic               baud_last;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push, pop;

  assign ready_out = (count != FIFO_FULL);
  assign push      = valid_in && ready_out;
  assign pop       = (state == IDLE) && (count != '0);
  assign baud_last = (baud == BAUD_LAST);

  always_ff @(posedge clk_200mhz) begin
    if (push) mem[wr_ptr] <= pixel_in;
  end

  // Pointers are exactly PTR_W bits wide, so the wrap is the natural overflow.
  always_ff @(posedge clk_200mhz or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_200mhz or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      baud       <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      pix_cnt    <= '0;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      baud       <= baud_d;
      bit_idx    <= bit_idx_d;
      shift_reg  <= shift_d;
      pix_cnt    <= pix_d;
      tx_out     <= tx_d;
      busy       <= busy_d;
      frame_done <= done_d;
    end
  end

  // Line outputs are registered copies of the current state, so the line lags the FSM by one cycle.
  always_comb begin
    state_d   = state;
    baud_d    = baud;
    bit_idx_d = bit_idx;
    shift_d   = shift_reg;
    pix_d     = pix_cnt;
    tx_d      = 1'b1;
    busy_d    = 1'b1;
    done_d    = 1'b0;

    case (state)
      IDLE: begin
        busy_d    = 1'b0;
        baud_d    = '0;
        bit_idx_d = '0;
        if (pop) begin
          shift_d = mem[rd_ptr];
          state_d = START;
        end
      end

      START: begin
        tx_d = 1'b0;
        if (baud_last) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud + BAUD_W'(1);
        end
      end

      DATA: begin
        tx_d = shift_reg[bit_idx];
        if (baud_last) begin
          baud_d = '0;
          if (bit_idx == 3'd7) begin
            bit_idx_d = '0;
`ifdef SERIALIZER_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end else begin
          baud_d = baud + BAUD_W'(1);
        end
      end

`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        tx_d = ^shift_reg;
        if (baud_last) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d = baud + BAUD_W'(1);
        end
      end
`endif

      STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = IDLE;
          if (pix_cnt == PIX_LAST) begin
            pix_d  = '0;
            done_d = 1'b1;
          end else begin
            pix_d = pix_cnt + PIX_W'(1);
          end
        end else begin
          baud_d = baud + BAUD_W'(1);
        end
      end

      default: begin
        busy_d  = 1'b0;
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pixel_uart_serializer.sv
// tb/tb_pixel_uart_serializer.sv - self-checking bench for pixel_uart_serializer (CLKS_PER_BIT=4, FIFO_DEPTH=16, FRAME_PIXELS=4)
module tb_pixel_uart_serializer;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int FPIX  = 4;
`ifdef SERIALIZER_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME_CYC = NB * CPB;

  logic       clk_200mhz = 1'b0;
  logic       reset_n    = 1'b0;
  logic [7:0] pixel_in   = '0;
  logic       valid_in   = 1'b0;
  logic       ready_out, tx_out, busy, frame_done;

  pixel_uart_serializer #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .FRAME_PIXELS(FPIX)
  ) dut (
    .clk_200mhz(clk_200mhz),
    .reset_n   (reset_n),
    .pixel_in  (pixel_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .tx_out    (tx_out),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk_200mhz = ~clk_200mhz;

  int cyc = 0;
  always @(posedge clk_200mhz) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  logic [7:0] sb[$];
  int         starts[$];
  int         done_cycs[$];

  // UART receiver: samples each bit mid-cell and checks bytes against the scoreboard.
  logic       mon_act = 1'b0;
  int         mon_t   = 0;
  logic [10:0] mon_bits;
  logic [7:0] exp_px;
  initial begin
    forever begin
      @(negedge clk_200mhz);
      if (!reset_n) begin
        mon_act = 1'b0;
      end else if (!mon_act) begin
        if (tx_out == 1'b0) begin
          mon_act  = 1'b1;
          mon_t    = 0;
          mon_bits = '0;
          starts.push_back(cyc);
        end
      end else begin
        mon_t++;
      end
      if (mon_act && reset_n && (mon_t % CPB) == CPB / 2) begin
        mon_bits[mon_t / CPB] = tx_out;
        if (mon_t / CPB == NB - 1) begin
          mon_act = 1'b0;
          if (sb.size() == 0) begin
            chk("unexpected_frame", 1, 0);
          end else begin
            exp_px = sb.pop_front();
            chk("uart_byte", mon_bits[8:1], exp_px);
            chk("uart_start_stop", {mon_bits[0], mon_bits[NB-1]}, 2'b01);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_200mhz);
      if (reset_n && frame_done) done_cycs.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic wait_drain(input int limit, input string name);
    int k;
    k = 0;
    while ((sb.size() != 0 || busy || mon_act) && k < limit) begin
      @(negedge clk_200mhz);
      k++;
    end
    chk(name, (k < limit) ? 1 : 0, 1);
    repeat (4) @(negedge clk_200mhz);
  endtask

  typedef struct {
    logic [7:0]  px;
    logic [10:0] bits;
  } vec_t;

  vec_t vecs[5];

  int acc, busy_n, first_low, p, full_at, guard, n0, bad, lows;
  logic [10:0] got;

  initial begin
`ifdef SERIALIZER_PARITY_EN
    vecs[0] = '{8'hA5, 11'b1_0_10100101_0};
    vecs[1] = '{8'h01, 11'b1_1_00000001_0};
    vecs[2] = '{8'h00, 11'b1_0_00000000_0};
    vecs[3] = '{8'hFF, 11'b1_0_11111111_0};
    vecs[4] = '{8'h80, 11'b1_1_10000000_0};
`else
    vecs[0] = '{8'hA5, 11'b0_1_10100101_0};
    vecs[1] = '{8'h01, 11'b0_1_00000001_0};
    vecs[2] = '{8'h00, 11'b0_1_00000000_0};
    vecs[3] = '{8'hFF, 11'b0_1_11111111_0};
    vecs[4] = '{8'h80, 11'b0_1_10000000_0};
`endif

    // Reset state
    repeat (3) @(negedge clk_200mhz);
    chk("rst_tx", tx_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    reset_n = 1'b1;
    @(negedge clk_200mhz);
    chk("rst_ready", ready_out, 1);

    // Single pixels into an idle block
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_200mhz);
      pixel_in = vecs[i].px;
      valid_in = 1'b1;
      sb.push_back(vecs[i].px);
      @(negedge clk_200mhz);
      valid_in  = 1'b0;
      acc       = cyc;
      busy_n    = 0;
      first_low = -1;
      got       = '0;
      for (int t = 0; t < FRAME_CYC + 12; t++) begin
        if (t > 0) @(negedge clk_200mhz);
        if (busy) busy_n++;
        if (first_low < 0 && tx_out == 1'b0) first_low = t;
        if (first_low >= 0 && (t - first_low) % CPB == CPB / 2 && (t - first_low) / CPB < NB)
          got[(t - first_low) / CPB] = tx_out;
      end
      chk("vec_latency", first_low, 2);
      chk("vec_busy_cycles", busy_n, FRAME_CYC);
      chk("vec_bits", got, vecs[i].bits);
    end

    // Push on the same cycle that IDLE pops the only entry
    n0 = starts.size();
    @(negedge clk_200mhz);
    pixel_in = 8'h3C; valid_in = 1'b1; sb.push_back(8'h3C);
    @(negedge clk_200mhz);
    chk("pp_ready", ready_out, 1);
    pixel_in = 8'hC3; sb.push_back(8'hC3);
    @(negedge clk_200mhz);
    valid_in = 1'b0;
    wait_drain(300, "pp_drain");
    chk("pp_frames", starts.size() - n0, 2);
    if (starts.size() - n0 == 2) chk("pp_gap", starts[n0+1] - starts[n0], FRAME_CYC + 1);

    // Backpressure: 20 incrementing pixels with valid_in held
    n0 = starts.size();
    p = 0; full_at = -1; guard = 0;
    @(negedge clk_200mhz);
    pixel_in = 8'h00; valid_in = 1'b1;
    while (p < 20 && guard < 3000) begin
      guard++;
      if (ready_out) begin
        sb.push_back(pixel_in);
        p++;
      end else if (full_at < 0) begin
        full_at = p;
      end
      @(negedge clk_200mhz);
      pixel_in = 8'(p);
    end
    valid_in = 1'b0;
    chk("bp_all_accepted", p, 20);
    chk("bp_full_after", full_at, 17);
    wait_drain(2000, "bp_drain");
    chk("bp_frames", starts.size() - n0, 20);
    bad = 0;
    for (int i = n0 + 1; i < starts.size(); i++)
      if (starts[i] - starts[i-1] != FRAME_CYC + 1) bad++;
    chk("bp_bad_gaps", bad, 0);

    // Reset in the middle of a frame with the FIFO still holding data
    @(negedge clk_200mhz);
    pixel_in = 8'h00; valid_in = 1'b1; sb.push_back(8'h00);
    @(negedge clk_200mhz);
    pixel_in = 8'h66;
    @(negedge clk_200mhz);
    pixel_in = 8'h77;
    @(negedge clk_200mhz);
    valid_in = 1'b0;
    repeat (12) @(negedge clk_200mhz);
    chk("midrst_pre_tx", tx_out, 0);
    chk("midrst_pre_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_tx", tx_out, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_frame_done", frame_done, 0);
    sb.delete();
    repeat (3) @(negedge clk_200mhz);
    reset_n = 1'b1;
    @(negedge clk_200mhz);
    chk("midrst_ready", ready_out, 1);
    lows = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk_200mhz);
      if (tx_out == 1'b0 || busy) lows++;
    end
    chk("midrst_quiet_line", lows, 0);

    // Image boundary: 8 pixels with FRAME_PIXELS=4 gives pulses on pixels 4 and 8
    done_cycs.delete();
    n0 = starts.size();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_200mhz);
      pixel_in = 8'hF0 + 8'(i);
      valid_in = 1'b1;
      sb.push_back(8'hF0 + 8'(i));
    end
    @(negedge clk_200mhz);
    valid_in = 1'b0;
    wait_drain(800, "fd_drain");
    chk("fd_frames", starts.size() - n0, 8);
    chk("fd_pulses", done_cycs.size(), 2);
    if (starts.size() - n0 == 8 && done_cycs.size() == 2) begin
      chk("fd_first_at", done_cycs[0], starts[n0+3] + FRAME_CYC - 1);
      chk("fd_second_at", done_cycs[1], starts[n0+7] + FRAME_CYC - 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pixel_uart_serializer.md
Name: pixel_uart_serializer

Overview:
- Sink end of the 8-bit pixel valid/ready stream leaving the pooling stage.
- Buffers pixels in a small FIFO and drives ready_out as backpressure.
- Sends each pixel as an 8N1 UART frame on tx_out toward the host link.
- Counts transmitted pixels and flags end-of-image so the host can re-align frames.

Parameters:
- CLKS_PER_BIT, 1736, clk_200mhz cycles per UART bit (200 MHz / 115200 baud); minimum 2.
- FIFO_DEPTH, 16, pixel FIFO entries; power of two, minimum 2.
- FRAME_PIXELS, 3721, pixels per image (61x61); frame_done pulses after this many transmitted pixels.

Ports:
- clk_200mhz  input  1  system clock.
- reset_n  input  1  reset, asynchronous, active-low.
- pixel_in  input  8  pixel from the pooling stage.
- valid_in  input  1  pixel_in is valid.
- ready_out  output  1  block can accept a pixel this cycle.
- tx_out  output  1  UART serial line, idle high.
- busy  output  1  a UART frame is in progress.
- frame_done  output  1  one-cycle pulse when the last pixel of an image completes its stop bit.

Behaviour:
- Reset (asynchronous, reset_n low): tx_out=1, busy=0, frame_done=0, FIFO count=0, read/write pointers=0, bit counter=0, baud counter=0, pixel counter=0, FSM=IDLE. ready_out=1 as soon as reset is released (FIFO empty).
- Reset mid-frame: tx_out returns to 1 immediately, and FIFO contents and the partial frame are discarded.
- Handshake:
  - A pixel is accepted on a rising edge where valid_in=1 and ready_out=1.
  - ready_out = (count != FIFO_DEPTH), decoded combinationally from the registered count.
  - When valid_in=1 and ready_out=0, nothing is written. Upstream may hold valid_in and pixel_in; the held pixel is accepted later, not lost.
- FIFO:
  - First-in, first-out ordering; pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - A pop never occurs when count==0.
  - A push never occurs when count==FIFO_DEPTH.
- FSM (all outputs registered):
  - IDLE: tx_out=1, busy=0. If count>0, pop the head into shift_reg and go to START. The pop happens in the cycle after the push at the earliest, so tx_out falls 2 cycles after acceptance into an empty, idle block.
  - START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles, with the bit index counting 0..7. After bit 7, go to PARITY if the optional feature is enabled, else STOP.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles. On the last cycle, increment the pixel counter and return to IDLE.
  - Back-to-back frames: if the FIFO is non-empty in IDLE, the next START begins on the following cycle, giving exactly 1 extra idle-high cycle between frames.
- busy: 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and reloads to 0 on every state/bit change.
  - A frame lasts exactly 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
- Pixel counter:
  - Width is clog2(FRAME_PIXELS+1).
  - When it reaches FRAME_PIXELS at the end of a stop bit, frame_done=1 for that single cycle and the counter wraps to 0.
  - frame_done is 0 at all other times.
- No combinational path from valid_in to ready_out.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles. It carries the even parity bit, the XOR of the 8 data bits. Frame becomes 8E1, 11 bit-times.
- Undefined: no PARITY state and no parity logic; frame is 8N1, 10 bit-times.

Test Plan:
- Reset: assert reset_n=0 mid-run -> tx_out=1, busy=0, frame_done=0, ready_out=1 after release; no further tx edges until a new pixel is accepted.
- Single pixel (CLKS_PER_BIT=4), push 0xA5 -> tx_out falls 2 cycles after acceptance; 0 for 4 cycles; then 1,0,1,0,0,1,0,1 each for 4 cycles; then 1 for 4 cycles; busy high for exactly 40 cycles.
- Backpressure (FIFO_DEPTH=16, CLKS_PER_BIT=4), hold valid_in=1 with 20 incrementing pixels 0x00..0x13 -> ready_out drops when count hits 16; the held pixel is accepted after the next pop; UART decodes 0x00..0x13 in order, none dropped or duplicated; inter-frame gap is exactly 1 cycle.
- Frame boundary (FRAME_PIXELS=4), send 5 pixels -> frame_done pulses once, for 1 cycle, at the final stop-bit cycle of pixel 4; no pulse for pixel 5; the counter restarts.
- Simultaneous push/pop: push into a FIFO holding 1 entry on the same cycle IDLE pops -> count stays 1 and ordering is preserved.
- SERIALIZER_PARITY_EN defined:
  - 0xA5 -> parity bit 0, frame 44 cycles.
  - 0x01 -> parity bit 1.
